// File: rtl/wr_ptr_full_pkg.sv
// wr_ptr_full_pkg: shared FIFO sizing constants and the binary-to-Gray helper
//   FIFO_ADDR_WIDTH : memory address bits (depth = 2**FIFO_ADDR_WIDTH)
//   FIFO_PTR_WIDTH  : pointer width, one extra wrap bit to tell full from empty
//   gray()          : binary to reflected Gray code, shared by both pointer blocks
package wr_ptr_full_pkg;
   localparam int FIFO_ADDR_WIDTH = 3;
   localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;
   function automatic logic [31:0] gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/wr_ptr_full_gray_encode.sv
// wr_ptr_full_gray_encode: combinational binary-to-Gray converter
//   bin      : binary input, W bits
//   gray_out : Gray-coded output, W bits
module wr_ptr_full_gray_encode
   import wr_ptr_full_pkg::*;
#(
   parameter int W = FIFO_PTR_WIDTH
) (
   input  logic [W-1:0] bin,
   output logic [W-1:0] gray_out
);
   assign gray_out = W'(gray(32'(bin)));
endmodule

// File: rtl/wr_ptr_full.sv
// wr_ptr_full: async-FIFO write pointer, Gray pointer export and full/overflow flags
//   w_clk        : write-domain clock
//   w_rst        : asynchronous active-low reset
//   w_inc        : producer write request
//   rq2_gray_ptr : read pointer (Gray), already synchronized into w_clk
//   w_addr       : write address into the FIFO memory
//   w_gray_ptr   : registered Gray write pointer for the read-domain synchronizer
//   w_full       : registered full flag
//   w_en         : memory write enable, w_inc gated by full and reset
//   w_ovf        : sticky flag, set by any write attempted while full
module wr_ptr_full
   import wr_ptr_full_pkg::*;
#(
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  w_clk,
   input  logic                  w_rst,
   input  logic                  w_inc,
   input  logic [ADDR_WIDTH:0]   rq2_gray_ptr,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH:0]   w_gray_ptr,
   output logic                  w_full,
   output logic                  w_en,
   output logic                  w_ovf
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] full_match;

   assign w_en      = w_inc & ~w_full & w_rst;
   assign w_addr    = wbin[ADDR_WIDTH-1:0];
   assign wbin_next = wbin + PW'(w_en);

   // Full when the write pointer is exactly one lap ahead of the read pointer;
   // in Gray code a half-range offset inverts the two top bits.
   assign full_match = {~rq2_gray_ptr[PW-1:PW-2], rq2_gray_ptr[PW-3:0]};

   wr_ptr_full_gray_encode #(.W(PW)) gray_encode (
      .bin      (wbin_next),
      .gray_out (gray_next)
   );

   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         wbin       <= '0;
         w_gray_ptr <= '0;
         w_full     <= 1'b0;
         w_ovf      <= 1'b0;
      end else begin
         wbin       <= wbin_next;
         w_gray_ptr <= gray_next;
         w_full     <= (gray_next == full_match);
         w_ovf      <= w_ovf | (w_inc & w_full);
      end
   end
endmodule
